// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures the execute-stage bundle and arbitrates
// flush / hold / bubble / load between EX-side and MEM-side stalls.
module ex_mem_reg #(
    parameter int unsigned SIMD_DW = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LD_W    = 3,
    parameter int unsigned ST_W    = 2,
    parameter int unsigned FEXC_W  = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               IDEX_Valid,
    input  logic [ADDR_W-1:0]  IDEX_NowPC,
    input  logic [4:0]         IDEX_RdAddr,
    input  logic               IDEX_RegWrite,
    input  logic               IDEX_FpRegWrite,
    input  logic [LD_W-1:0]    IDEX_LdType,
    input  logic [ST_W-1:0]    IDEX_StType,
    input  logic [SIMD_DW-1:0] IDEX_Rs2Data,
    input  logic               IDEX_FpuOp,
    input  logic [SIMD_DW-1:0] EX_AluData,
    input  logic               EX_LdStFlag,
    input  logic [FEXC_W-1:0]  EX_FpuException,
    input  logic               EX_FpuReady,
    input  logic               EX_StallReq,
    input  logic               Mem_StallReq,
    input  logic               Flush,
    output logic               EXMEM_Valid,
    output logic [ADDR_W-1:0]  EXMEM_NowPC,
    output logic [4:0]         EXMEM_RdAddr,
    output logic               EXMEM_RegWrite,
    output logic               EXMEM_FpRegWrite,
    output logic [LD_W-1:0]    EXMEM_LdType,
    output logic [ST_W-1:0]    EXMEM_StType,
    output logic [SIMD_DW-1:0] EXMEM_StData,
    output logic [SIMD_DW-1:0] EXMEM_AluData,
    output logic               EXMEM_LdStFlag,
    output logic               EXMEM_FflagsWe,
    output logic [FEXC_W-1:0]  EXMEM_Fflags,
    output logic [CNT_W-1:0]   EXMEM_BubbleCnt,
    output logic               EX_Accept
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_e;

    act_e act;
    logic cnt_sat;

    // Per-cycle arbitration: flush > memory stall > execute stall > load.
    always_comb begin
        act = ACT_LOAD;
        if (Flush) begin
            act = ACT_FLUSH;
        end else if (Mem_StallReq) begin
            act = ACT_HOLD;
        end else if (EX_StallReq || (IDEX_FpuOp && !EX_FpuReady)) begin
            act = ACT_BUBBLE;
        end
    end

    assign EX_Accept = (act == ACT_LOAD) && IDEX_Valid;
    assign cnt_sat   = (EXMEM_BubbleCnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EXMEM_Valid      <= 1'b0;
            EXMEM_NowPC      <= '0;
            EXMEM_RdAddr     <= '0;
            EXMEM_RegWrite   <= 1'b0;
            EXMEM_FpRegWrite <= 1'b0;
            EXMEM_LdType     <= '0;
            EXMEM_StType     <= '0;
            EXMEM_StData     <= '0;
            EXMEM_AluData    <= '0;
            EXMEM_LdStFlag   <= 1'b0;
            EXMEM_FflagsWe   <= 1'b0;
            EXMEM_Fflags     <= '0;
            EXMEM_BubbleCnt  <= '0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    // Control fields are gated so an invalid slot never writes.
                    EXMEM_Valid      <= IDEX_Valid;
                    EXMEM_NowPC      <= IDEX_NowPC;
                    EXMEM_RdAddr     <= IDEX_RdAddr;
                    EXMEM_RegWrite   <= IDEX_Valid & IDEX_RegWrite;
                    EXMEM_FpRegWrite <= IDEX_Valid & IDEX_FpRegWrite;
                    EXMEM_LdType     <= IDEX_Valid ? IDEX_LdType : '0;
                    EXMEM_StType     <= IDEX_Valid ? IDEX_StType : '0;
                    EXMEM_StData     <= IDEX_Rs2Data;
                    EXMEM_AluData    <= EX_AluData;
                    EXMEM_LdStFlag   <= EX_LdStFlag;
                    EXMEM_FflagsWe   <= IDEX_Valid & IDEX_FpuOp;
                    EXMEM_Fflags     <= EX_FpuException;
                end
                ACT_HOLD: begin
                    // Drop the flag strobe so held flags are committed only once.
                    EXMEM_FflagsWe <= 1'b0;
                end
                ACT_BUBBLE: begin
                    EXMEM_Valid      <= 1'b0;
                    EXMEM_RegWrite   <= 1'b0;
                    EXMEM_FpRegWrite <= 1'b0;
                    EXMEM_LdType     <= '0;
                    EXMEM_StType     <= '0;
                    EXMEM_FflagsWe   <= 1'b0;
                    if (IDEX_Valid && !cnt_sat) begin
                        EXMEM_BubbleCnt <= EXMEM_BubbleCnt + CNT_W'(1);
                    end
                end
                default: begin
                    EXMEM_Valid      <= 1'b0;
                    EXMEM_RegWrite   <= 1'b0;
                    EXMEM_FpRegWrite <= 1'b0;
                    EXMEM_LdType     <= '0;
                    EXMEM_StType     <= '0;
                    EXMEM_FflagsWe   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed table-driven bench for ex_mem_reg, plus reset and counter
// saturation sequences (a 2-bit counter instance stands in for 32-bit).
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IDEX_Valid, IDEX_RegWrite, IDEX_FpRegWrite, IDEX_FpuOp;
    logic [31:0] IDEX_NowPC;
    logic [4:0]  IDEX_RdAddr;
    logic [2:0]  IDEX_LdType;
    logic [1:0]  IDEX_StType;
    logic [63:0] IDEX_Rs2Data, EX_AluData;
    logic        EX_LdStFlag, EX_FpuReady, EX_StallReq, Mem_StallReq, Flush;
    logic [4:0]  EX_FpuException;

    logic        o_valid, o_rw, o_fprw, o_ldst, o_fwe, o_acc;
    logic [31:0] o_pc, o_cnt;
    logic [4:0]  o_rd, o_ffl;
    logic [2:0]  o_ld;
    logic [1:0]  o_st;
    logic [63:0] o_std, o_alu;

    logic        s_valid, s_rw, s_fprw, s_ldst, s_fwe, s_acc;
    logic [31:0] s_pc;
    logic [1:0]  s_cnt;
    logic [4:0]  s_rd, s_ffl;
    logic [2:0]  s_ld;
    logic [1:0]  s_st;
    logic [63:0] s_std, s_alu;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst_n(rst_n),
        .IDEX_Valid(IDEX_Valid), .IDEX_NowPC(IDEX_NowPC), .IDEX_RdAddr(IDEX_RdAddr),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_FpRegWrite(IDEX_FpRegWrite),
        .IDEX_LdType(IDEX_LdType), .IDEX_StType(IDEX_StType), .IDEX_Rs2Data(IDEX_Rs2Data),
        .IDEX_FpuOp(IDEX_FpuOp), .EX_AluData(EX_AluData), .EX_LdStFlag(EX_LdStFlag),
        .EX_FpuException(EX_FpuException), .EX_FpuReady(EX_FpuReady),
        .EX_StallReq(EX_StallReq), .Mem_StallReq(Mem_StallReq), .Flush(Flush),
        .EXMEM_Valid(o_valid), .EXMEM_NowPC(o_pc), .EXMEM_RdAddr(o_rd),
        .EXMEM_RegWrite(o_rw), .EXMEM_FpRegWrite(o_fprw), .EXMEM_LdType(o_ld),
        .EXMEM_StType(o_st), .EXMEM_StData(o_std), .EXMEM_AluData(o_alu),
        .EXMEM_LdStFlag(o_ldst), .EXMEM_FflagsWe(o_fwe), .EXMEM_Fflags(o_ffl),
        .EXMEM_BubbleCnt(o_cnt), .EX_Accept(o_acc)
    );

    ex_mem_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .IDEX_Valid(IDEX_Valid), .IDEX_NowPC(IDEX_NowPC), .IDEX_RdAddr(IDEX_RdAddr),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_FpRegWrite(IDEX_FpRegWrite),
        .IDEX_LdType(IDEX_LdType), .IDEX_StType(IDEX_StType), .IDEX_Rs2Data(IDEX_Rs2Data),
        .IDEX_FpuOp(IDEX_FpuOp), .EX_AluData(EX_AluData), .EX_LdStFlag(EX_LdStFlag),
        .EX_FpuException(EX_FpuException), .EX_FpuReady(EX_FpuReady),
        .EX_StallReq(EX_StallReq), .Mem_StallReq(Mem_StallReq), .Flush(Flush),
        .EXMEM_Valid(s_valid), .EXMEM_NowPC(s_pc), .EXMEM_RdAddr(s_rd),
        .EXMEM_RegWrite(s_rw), .EXMEM_FpRegWrite(s_fprw), .EXMEM_LdType(s_ld),
        .EXMEM_StType(s_st), .EXMEM_StData(s_std), .EXMEM_AluData(s_alu),
        .EXMEM_LdStFlag(s_ldst), .EXMEM_FflagsWe(s_fwe), .EXMEM_Fflags(s_ffl),
        .EXMEM_BubbleCnt(s_cnt), .EX_Accept(s_acc)
    );

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        rw, fprw;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic        fop;
        logic [63:0] alu;
        logic [4:0]  fexc;
        logic        frdy, exs, mems, fl;
        logic        e_acc, e_vld;
        logic [31:0] e_pc;
        logic        e_rw, e_fprw;
        logic [2:0]  e_ld;
        logic [1:0]  e_st;
        logic [63:0] e_alu;
        logic        e_fwe;
        logic [4:0]  e_ffl;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Rd, store data and LdStFlag are derived from PC/ALU so they can be checked too.
    task automatic set_in(input vec_t v);
        IDEX_Valid      = v.vld;
        IDEX_NowPC      = v.pc;
        IDEX_RdAddr     = v.pc[6:2];
        IDEX_RegWrite   = v.rw;
        IDEX_FpRegWrite = v.fprw;
        IDEX_LdType     = v.ld;
        IDEX_StType     = v.st;
        IDEX_Rs2Data    = ~v.alu;
        IDEX_FpuOp      = v.fop;
        EX_AluData      = v.alu;
        EX_LdStFlag     = v.pc[2];
        EX_FpuException = v.fexc;
        EX_FpuReady     = v.frdy;
        EX_StallReq     = v.exs;
        Mem_StallReq    = v.mems;
        Flush           = v.fl;
    endtask

    function automatic vec_t idle();
        vec_t v = '{default: '0};
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 64'(o_valid), 64'd0);
        chk({tag, " pc"},    64'(o_pc),    64'd0);
        chk({tag, " rd"},    64'(o_rd),    64'd0);
        chk({tag, " rw"},    64'(o_rw),    64'd0);
        chk({tag, " fprw"},  64'(o_fprw),  64'd0);
        chk({tag, " ld"},    64'(o_ld),    64'd0);
        chk({tag, " st"},    64'(o_st),    64'd0);
        chk({tag, " stdata"}, o_std,       64'd0);
        chk({tag, " alu"},   o_alu,        64'd0);
        chk({tag, " ldst"},  64'(o_ldst),  64'd0);
        chk({tag, " fwe"},   64'(o_fwe),   64'd0);
        chk({tag, " fflags"}, 64'(o_ffl),  64'd0);
        chk({tag, " cnt"},   64'(o_cnt),   64'd0);
    endtask

    initial begin
        vec_t v;
        //         vld pc        rw fprw ld    st    fop alu    fexc   rdy exs mems fl | acc vld pc       rw fprw ld   st    alu   fwe ffl   cnt
        vt[0]  = '{1, 32'h100, 1, 0, 3'd0, 2'd0, 0, 64'h11, 5'h00, 0, 0, 0, 0,  1, 1, 32'h100, 1, 0, 3'd0, 2'd0, 64'h11, 0, 5'h00, 0};
        vt[1]  = '{1, 32'h104, 1, 0, 3'd0, 2'd0, 0, 64'h22, 5'h00, 0, 0, 0, 0,  1, 1, 32'h104, 1, 0, 3'd0, 2'd0, 64'h22, 0, 5'h00, 0};
        vt[2]  = '{1, 32'h108, 1, 0, 3'd0, 2'd0, 0, 64'h33, 5'h00, 0, 0, 0, 0,  1, 1, 32'h108, 1, 0, 3'd0, 2'd0, 64'h33, 0, 5'h00, 0};
        for (int i = 0; i < 4; i++)
            vt[3+i] = '{1, 32'h10C, 1, 0, 3'd0, 2'd0, 0, 64'h07, 5'h00, 0, 1, 0, 0,  0, 0, 32'h108, 0, 0, 3'd0, 2'd0, 64'h33, 0, 5'h00, 32'(i+1)};
        vt[7]  = '{1, 32'h10C, 1, 0, 3'd0, 2'd0, 0, 64'h07, 5'h00, 0, 0, 0, 0,  1, 1, 32'h10C, 1, 0, 3'd0, 2'd0, 64'h07, 0, 5'h00, 4};
        vt[8]  = '{1, 32'h110, 1, 0, 3'd2, 2'd0, 0, 64'h40, 5'h00, 0, 0, 0, 0,  1, 1, 32'h110, 1, 0, 3'd2, 2'd0, 64'h40, 0, 5'h00, 4};
        for (int i = 0; i < 3; i++)
            vt[9+i] = '{1, 32'h114, 0, 1, 3'd0, 2'd0, 1, 64'h41, 5'h01, 1, 0, 1, 0,  0, 1, 32'h110, 1, 0, 3'd2, 2'd0, 64'h40, 0, 5'h00, 4};
        vt[12] = '{1, 32'h114, 0, 1, 3'd0, 2'd0, 1, 64'h41, 5'h01, 1, 0, 0, 0,  1, 1, 32'h114, 0, 1, 3'd0, 2'd0, 64'h41, 1, 5'h01, 4};
        vt[13] = '{1, 32'h118, 0, 0, 3'd0, 2'd1, 0, 64'h55, 5'h00, 0, 0, 0, 0,  1, 1, 32'h118, 0, 0, 3'd0, 2'd1, 64'h55, 0, 5'h00, 4};
        vt[14] = '{1, 32'h11C, 1, 0, 3'd0, 2'd1, 0, 64'h66, 5'h00, 0, 1, 1, 1,  0, 0, 32'h118, 0, 0, 3'd0, 2'd0, 64'h55, 0, 5'h00, 4};
        vt[15] = '{1, 32'h120, 0, 1, 3'd0, 2'd0, 1, 64'h77, 5'h00, 0, 0, 0, 0,  0, 0, 32'h118, 0, 0, 3'd0, 2'd0, 64'h55, 0, 5'h00, 5};
        vt[16] = '{1, 32'h120, 0, 1, 3'd0, 2'd0, 1, 64'h77, 5'h10, 1, 0, 0, 0,  1, 1, 32'h120, 0, 1, 3'd0, 2'd0, 64'h77, 1, 5'h10, 5};
        vt[17] = '{0, 32'h124, 1, 0, 3'd0, 2'd0, 0, 64'h88, 5'h00, 0, 1, 0, 0,  0, 0, 32'h120, 0, 0, 3'd0, 2'd0, 64'h77, 0, 5'h10, 5};
        vt[18] = '{0, 32'h124, 1, 1, 3'd3, 2'd2, 0, 64'h88, 5'h03, 0, 0, 0, 0,  0, 0, 32'h124, 0, 0, 3'd0, 2'd0, 64'h88, 0, 5'h03, 5};

        set_in(idle());
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            set_in(vt[i]);
            #1;
            chk($sformatf("v%0d accept", i), 64'(o_acc), 64'(vt[i].e_acc));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i),  64'(o_valid), 64'(vt[i].e_vld));
            chk($sformatf("v%0d pc", i),     64'(o_pc),    64'(vt[i].e_pc));
            chk($sformatf("v%0d rd", i),     64'(o_rd),    64'(vt[i].e_pc[6:2]));
            chk($sformatf("v%0d rw", i),     64'(o_rw),    64'(vt[i].e_rw));
            chk($sformatf("v%0d fprw", i),   64'(o_fprw),  64'(vt[i].e_fprw));
            chk($sformatf("v%0d ld", i),     64'(o_ld),    64'(vt[i].e_ld));
            chk($sformatf("v%0d st", i),     64'(o_st),    64'(vt[i].e_st));
            chk($sformatf("v%0d alu", i),    o_alu,        vt[i].e_alu);
            chk($sformatf("v%0d stdata", i), o_std,        ~vt[i].e_alu);
            chk($sformatf("v%0d ldst", i),   64'(o_ldst),  64'(vt[i].e_pc[2]));
            chk($sformatf("v%0d fwe", i),    64'(o_fwe),   64'(vt[i].e_fwe));
            chk($sformatf("v%0d fflags", i), 64'(o_ffl),   64'(vt[i].e_ffl));
            chk($sformatf("v%0d cnt", i),    64'(o_cnt),   64'(vt[i].e_cnt));
        end

        // Asynchronous reset asserted mid-cycle with a valid op loaded.
        @(negedge clk);
        v = idle();
        v.vld = 1; v.pc = 32'h200; v.rw = 1; v.ld = 3'd1; v.st = 2'd1; v.alu = 64'h99; v.fop = 1; v.frdy = 1; v.fexc = 5'h04;
        set_in(v);
        @(posedge clk);
        #1;
        chk("rst pre valid", 64'(o_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst async");
        @(negedge clk);
        set_in(idle());
        rst_n = 1'b1;

        // Bubble counter saturation on the 2-bit instance; 32-bit keeps counting.
        v = idle();
        v.vld = 1; v.pc = 32'h300; v.exs = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(v);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d cnt2", i), 64'(s_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
            chk($sformatf("sat%0d cnt32", i), 64'(o_cnt), 64'(i + 1));
            chk($sformatf("sat%0d valid", i), 64'(s_valid), 64'd0);
        end

        // Reset during a memory-side hold; first cycle after release is empty.
        @(negedge clk);
        v = idle();
        v.vld = 1; v.pc = 32'h400; v.rw = 1; v.ld = 3'd4; v.alu = 64'hAB;
        set_in(v);
        @(posedge clk);
        @(negedge clk);
        v.mems = 1; v.pc = 32'h404;
        set_in(v);
        @(posedge clk);
        #1;
        chk("hold pc", 64'(o_pc), 64'h400);
        chk("hold ld", 64'(o_ld), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("hold rst valid", 64'(o_valid), 64'd0);
        chk("hold rst ld", 64'(o_ld), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(idle());
        @(posedge clk);
        #1;
        chk("post rst valid", 64'(o_valid), 64'd0);
        chk("post rst rw", 64'(o_rw), 64'd0);
        chk("post rst cnt", 64'(o_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register. Captures the execute-stage result bundle (ALU/M/FPU data, load/store control, store data, destination info, FPU exception flags) and presents it to the memory stage.
- Arbitrates hold / bubble / flush between the execute-side stall (multi-cycle divide, FPU) and the memory-side stall (D-cache miss).
- Keeps a saturating bubble counter for the performance CSRs.

Parameters:
- SIMD_DW, 64, width of ALU result and store data (SIMD data path).
- ADDR_W, 32, PC width.
- LD_W, 3, load-type code width; 0 means "no load".
- ST_W, 2, store-type code width; 0 means "no store".
- FEXC_W, 5, FPU exception flag width (NV,DZ,OF,UF,NX).
- CNT_W, 32, bubble counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- IDEX_Valid  in  1  instruction in EX is valid
- IDEX_NowPC  in  ADDR_W  PC of instruction in EX
- IDEX_RdAddr  in  5  destination register index
- IDEX_RegWrite  in  1  integer RF write enable
- IDEX_FpRegWrite  in  1  FP RF write enable
- IDEX_LdType  in  LD_W  load type
- IDEX_StType  in  ST_W  store type
- IDEX_Rs2Data  in  SIMD_DW  store data
- IDEX_FpuOp  in  1  instruction is an FPU op
- EX_AluData  in  SIMD_DW  execute result
- EX_LdStFlag  in  1  memory access address valid/aligned
- EX_FpuException  in  FEXC_W  FPU flags for current op
- EX_FpuReady  in  1  FPU result valid this cycle
- EX_StallReq  in  1  EX not finished (div/FPU busy)
- Mem_StallReq  in  1  MEM stage cannot accept (cache miss)
- Flush  in  1  trap/redirect flush of EX/MEM
- EXMEM_Valid  out  1  MEM-stage instruction valid
- EXMEM_NowPC  out  ADDR_W
- EXMEM_RdAddr  out  5
- EXMEM_RegWrite  out  1  gated by valid
- EXMEM_FpRegWrite  out  1  gated by valid
- EXMEM_LdType  out  LD_W  gated by valid
- EXMEM_StType  out  ST_W  gated by valid
- EXMEM_StData  out  SIMD_DW
- EXMEM_AluData  out  SIMD_DW
- EXMEM_LdStFlag  out  1
- EXMEM_FflagsWe  out  1  one-cycle pulse: OR FEXC into CSR fflags
- EXMEM_Fflags  out  FEXC_W
- EXMEM_BubbleCnt  out  CNT_W  saturating count of bubbles inserted
- EX_Accept  out  1  EX instruction consumed this cycle (ID/EX may advance)

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs and registers are 0, including EXMEM_Valid=0 and EXMEM_BubbleCnt=0.
- Priority per cycle, highest first:
  - (1) Flush.
  - (2) Mem_StallReq: HOLD.
  - (3) EX_StallReq, or IDEX_FpuOp with EX_FpuReady=0: BUBBLE.
  - (4) otherwise LOAD.
- FLUSH: Valid<=0; RegWrite/FpRegWrite/LdType/StType/FflagsWe <=0. Data fields don't-care (held). Bubble counter not incremented. EX_Accept=0.
- HOLD: every register keeps its value and FflagsWe<=0, so flags are committed only once. EX_Accept=0.
- BUBBLE: Valid<=0, all control fields <=0, FflagsWe<=0. BubbleCnt increments only if IDEX_Valid=1, saturating at all-ones. EX_Accept=0.
- LOAD: capture every IDEX_/EX_ field. Valid<=IDEX_Valid. EX_Accept=IDEX_Valid.
- FFLAGS on LOAD: FflagsWe<=IDEX_Valid & IDEX_FpuOp. Fflags<=EX_FpuException.
- Valid gating: control outputs (RegWrite, FpRegWrite, LdType, StType) never non-zero while Valid=0. Invalid LOAD captures zeros for them.
- Latency: 1 cycle EX→MEM. EX_Accept is combinational from current inputs.
- Flush together with Mem_StallReq: flush wins; the MEM-stage instruction is killed.
- Reset mid-hold: state is cleared immediately; the first cycle after release behaves as empty.
- Back-to-back LOADs sustain one instruction per cycle with no inserted bubble.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with Valid=1 loaded → all outputs 0 asynchronously, BubbleCnt=0.
- Stream: 3 valid ops, PCs 0x100/0x104/0x108, no stalls → EXMEM_NowPC follows 1 cycle later, Valid=1 each cycle, EX_Accept=1 each cycle.
- Divide stall: EX_StallReq=1 for 4 cycles with IDEX_Valid=1 → Valid=0 for 4 cycles, RegWrite=0, BubbleCnt=4; on release the op loads with EX_AluData=0x0000_0000_0000_0007.
- Cache stall: load in MEM (LdType=3'b010), Mem_StallReq=1 for 3 cycles → all outputs stable for 3 cycles. FPU op in EX with flags 5'b00001 loads once afterwards → FflagsWe high for exactly 1 cycle, Fflags=5'b00001.
- Flush priority: Flush=1 with Mem_StallReq=1 and EX_StallReq=1 → Valid=0 next cycle, StType=0, BubbleCnt unchanged, EX_Accept=0.
- Saturation: preload BubbleCnt to 0xFFFF_FFFE, apply 3 bubbles → 0xFFFF_FFFF and holds.
